// File: rtl/calc_pkg.sv
// Shared calculator constants: FSM state codes and default sizing
// for the sequential multiplier and divider control units.
package calc_pkg;

    localparam logic [2:0] START = 3'b000;
    localparam logic [2:0] SHIFT = 3'b001;
    localparam logic [2:0] CHECK = 3'b010;
    localparam logic [2:0] FIN   = 3'b100;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DONE_HOLD = 31;

endpackage

// File: rtl/div_shift_sub_if.sv
// Operand/result bundle between the calculator top and the divider.
// master drives init and operands, slave returns the result.
interface div_shift_sub_if
    import calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             init;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             div_by_zero;

    modport master (
        output init, dividend, divisor,
        input  quotient, remainder, done, div_by_zero
    );

    modport slave (
        input  init, dividend, divisor,
        output quotient, remainder, done, div_by_zero
    );
endinterface

// File: rtl/control_div.sv
// Divider control: START/SHIFT/CHECK/FIN sequencer with the
// bit counter and the done-hold counter.
module control_div
    import calc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DONE_HOLD = DEF_DONE_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic b_zero,
    input  logic r_ge_b,
    output logic load,
    output logic shift,
    output logic sub,
    output logic finish,
    output logic done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int HW = $clog2(DONE_HOLD + 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= START;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Next state and counter updates; unknown codes fall back to START
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            START: begin
                if (init) begin
                    cnt_d   = CW'(WIDTH);
                    hold_d  = '0;
                    state_d = b_zero ? FIN : SHIFT;
                end
            end
            SHIFT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                if (cnt_zero) begin
                    hold_d  = '0;
                    state_d = FIN;
                end else begin
                    state_d = SHIFT;
                end
            end
            FIN: begin
                if (hold_q == HW'(DONE_HOLD)) begin
                    state_d = START;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = START;
        endcase
    end

    // Datapath strobes decoded from the current state (Moore done)
    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        sub    = 1'b0;
        finish = 1'b0;
        done   = 1'b0;
        case (state_q)
            START: load = init;
            SHIFT: shift = 1'b1;
            CHECK: begin
                sub    = r_ge_b;
                finish = cnt_zero;
            end
            FIN:   done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/div_shift_sub.sv
// Sequential unsigned restoring divider: one shift and one
// compare/subtract cycle per quotient bit.
module div_shift_sub
    import calc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DONE_HOLD = DEF_DONE_HOLD
) (
    input logic           clk,
    input logic           rst,
    div_shift_sub_if.slave bus
);
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic load, shift, sub, finish, done;
    logic b_zero, r_ge_b;

    assign b_zero = (bus.divisor == '0);
    assign r_ge_b = (r_q >= {1'b0, b_q});

    control_div #(
        .WIDTH     (WIDTH),
        .DONE_HOLD (DONE_HOLD)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .init   (bus.init),
        .b_zero (b_zero),
        .r_ge_b (r_ge_b),
        .load   (load),
        .shift  (shift),
        .sub    (sub),
        .finish (finish),
        .done   (done)
    );

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            q_q    <= '0;
            b_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            b_q    <= b_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    // Load, shift, restore-compare and result capture on FIN entry
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        b_d    = b_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (load) begin
            q_d   = bus.dividend;
            b_d   = bus.divisor;
            r_d   = '0;
            dbz_d = b_zero;
            if (b_zero) begin
                quot_d = '1;
                rem_d  = bus.dividend;
            end
        end
        if (shift) begin
            r_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (sub) begin
            r_d = r_q - {1'b0, b_q};
            q_d = {q_q[WIDTH-1:1], 1'b1};
        end
        if (finish) begin
            quot_d = q_d;
            rem_d  = r_d[WIDTH-1:0];
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.done        = done;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_shift_sub.sv
// Scoreboard bench for div_shift_sub: directed cases, level init,
// mid-op reset and a random sweep against plain / and %.
module tb_div_shift_sub;
    localparam int W    = 8;
    localparam int HOLD = 31;
    localparam int LAT  = 2 * W;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    div_shift_sub_if #(.WIDTH(W)) bus ();

    div_shift_sub #(
        .WIDTH     (W),
        .DONE_HOLD (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each rising done
    logic done_prev = 1'b0;
    int   hi_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        int   eq, er, ez, lat;
        if (rst) begin
            done_prev = 1'b0;
            hi_cnt    = 0;
        end else begin
            if (bus.done && !done_prev) begin
                hi_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.t0;
                    if (e.b == 0) begin
                        eq = 255;
                        er = e.a;
                        ez = 1;
                        check("latency_bz_le1", int'(lat <= 1), 1);
                    end else begin
                        eq = e.a / e.b;
                        er = e.a % e.b;
                        ez = 0;
                        check("latency", lat, LAT);
                    end
                    check("quotient", bus.quotient, eq);
                    check("remainder", bus.remainder, er);
                    check("div_by_zero", bus.div_by_zero, ez);
                end
            end
            if (bus.done) hi_cnt = hi_cnt + 1;
            if (!bus.done && done_prev) check("done_hold", hi_cnt, HOLD + 1);
            done_prev = bus.done;
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("idle_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        @(negedge clk);
        bus.init     = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        e.a  = a;
        e.b  = b;
        e.t0 = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        bus.init     = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_quotient"}, bus.quotient, 0);
        check({tag, "_remainder"}, bus.remainder, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_dbz"}, bus.div_by_zero, 0);
    endtask

    initial begin
        exp_t e;
        int   t0;
        bus.init     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        issue(8'd100, 8'd7);
        issue(8'd255, 8'd1);
        issue(8'd5, 8'd9);
        issue(8'd255, 8'd255);
        issue(8'd42, 8'd0);
        issue(8'd10, 8'd3);

        // Reset seven cycles into a division
        issue(8'd200, 8'd9);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        rst = 1'b0;
        issue(8'd200, 8'd9);

        // Level init through a whole op, pulsed in FIN, operands moved
        wait_idle();
        @(negedge clk);
        bus.init     = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd13;
        @(posedge clk);
        #1;
        t0   = cyc;
        e.a  = 8'd200;
        e.b  = 8'd13;
        e.t0 = t0;
        exp_q.push_back(e);
        @(negedge clk);
        bus.dividend = 8'd77;
        bus.divisor  = 8'd6;
        e.a  = 8'd77;
        e.b  = 8'd6;
        e.t0 = t0 + LAT + HOLD + 2;
        exp_q.push_back(e);
        repeat (20) @(negedge clk);
        bus.init = 1'b0;
        @(negedge clk);
        bus.init = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (cyc >= t0 + LAT + HOLD + 2) break;
        end
        @(negedge clk);
        bus.init = 1'b0;

        // Random sweep, divisor zero now and then
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            issue(a, b);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
